parking_slot_controller: RTL and testbench

//   Owns the parking occupancy register and sequences every update to it.

---
 rtl/parking_slot_controller.sv | 233 +++++++++++++++++++++++
 tb/tb_parking_slot_controller.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_slot_controller.sv
// -----------------------------------------------------------------------------
// parking_slot_controller
//   Owns the parking occupancy register and serialises every update to it.
//   Entry and exit gates use a 4-phase req/ack handshake. When both gates
//   request in the same cycle, a toggling priority bit picks the side
//   (exit first after reset).
//   Entry takes the lowest-index free space. Exit releases a space only when
//   the given location is one-hot and currently occupied.
//   Each update is applied as occupancy ^ one-hot location.
//   Optional feature macro: PARK_STATS_EN builds saturating entry/reject
//   counters. When it is undefined, those outputs are tied to zero.
// -----------------------------------------------------------------------------
module parking_slot_controller #(
    parameter int N_SPOTS = 8,
    parameter int CNT_W   = $clog2(N_SPOTS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               entry_req,
    output logic               entry_ack,
    output logic               entry_reject,
    output logic [N_SPOTS-1:0] entry_loc,
    input  logic               exit_req,
    input  logic [N_SPOTS-1:0] exit_loc,
    output logic               exit_ack,
    output logic               exit_err,
    output logic [N_SPOTS-1:0] occupancy,
    output logic [CNT_W-1:0]   free_count,
    output logic               full,
    output logic               empty,
    output logic [15:0]        entry_total,
    output logic [15:0]        reject_total
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        SERVE_ENTRY = 2'd1,
        SERVE_EXIT  = 2'd2,
        WAIT_DROP   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0]   FULL_CNT  = CNT_W'(N_SPOTS);
    localparam logic [N_SPOTS-1:0] ZERO_LOC  = {N_SPOTS{1'b0}};
    localparam logic [N_SPOTS-1:0] ONE_LOC   = N_SPOTS'(1);

    // Number of set bits in an occupancy-sized vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [N_SPOTS-1:0] v);
        logic [CNT_W-1:0] c;
        c = {CNT_W{1'b0}};
        for (int i = 0; i < N_SPOTS; i++) begin
            c = c + CNT_W'(v[i]);
        end
        return c;
    endfunction

    // True when exactly one bit of v is set.
    function automatic logic is_one_hot(input logic [N_SPOTS-1:0] v);
        return (v != ZERO_LOC) && ((v & (v - ONE_LOC)) == ZERO_LOC);
    endfunction

    // One-hot of the lowest clear bit of occ. This is zero when occ is all ones,
    // because the +1 wraps to zero.
    function automatic logic [N_SPOTS-1:0] lowest_free(input logic [N_SPOTS-1:0] occ);
        return (~occ) & (occ + ONE_LOC);
    endfunction

    state_t             state_r;
    logic               served_entry_r;   // 1: the transaction in flight is an entry
    logic               prio_entry_r;     // 1: entry wins the next tie, 0: exit wins
    logic               entry_ack_r;
    logic               entry_reject_r;
    logic [N_SPOTS-1:0] entry_loc_r;
    logic               exit_ack_r;
    logic               exit_err_r;
    logic [N_SPOTS-1:0] occupancy_r;
    logic [CNT_W-1:0]   free_count_r;
    logic               full_r;
    logic               empty_r;

    logic [N_SPOTS-1:0] free_pick_s;
    logic               exit_ok_s;
    logic [N_SPOTS-1:0] upd_loc_s;
    logic [N_SPOTS-1:0] occ_next_s;
    logic               served_req_s;

    // Next occupancy: at most one XOR update, and only in a serve state.
    always_comb begin
        free_pick_s  = lowest_free(occupancy_r);
        exit_ok_s    = is_one_hot(exit_loc) && ((exit_loc & occupancy_r) != ZERO_LOC);
        upd_loc_s    = ZERO_LOC;
        served_req_s = served_entry_r ? entry_req : exit_req;
        case (state_r)
            SERVE_ENTRY: begin
                upd_loc_s = free_pick_s;
            end
            SERVE_EXIT: begin
                if (exit_ok_s) begin
                    upd_loc_s = exit_loc;
                end else begin
                    upd_loc_s = ZERO_LOC;
                end
            end
            default: begin
                upd_loc_s = ZERO_LOC;
            end
        endcase
        occ_next_s = occupancy_r ^ upd_loc_s;
    end

    // Handshake FSM. It also registers occupancy and the status flags derived
    // from the next occupancy value, so the flags never lag occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            served_entry_r <= 1'b0;
            prio_entry_r   <= 1'b0;
            entry_ack_r    <= 1'b0;
            entry_reject_r <= 1'b0;
            entry_loc_r    <= ZERO_LOC;
            exit_ack_r     <= 1'b0;
            exit_err_r     <= 1'b0;
            occupancy_r    <= ZERO_LOC;
            free_count_r   <= FULL_CNT;
            full_r         <= 1'b0;
            empty_r        <= 1'b1;
        end else begin
            occupancy_r  <= occ_next_s;
            free_count_r <= FULL_CNT - popcount(occ_next_s);
            full_r       <= &occ_next_s;
            empty_r      <= ~|occ_next_s;
            case (state_r)
                IDLE: begin
                    if (entry_req && exit_req) begin
                        if (prio_entry_r) begin
                            state_r        <= SERVE_ENTRY;
                            served_entry_r <= 1'b1;
                        end else begin
                            state_r        <= SERVE_EXIT;
                            served_entry_r <= 1'b0;
                        end
                        prio_entry_r <= ~prio_entry_r;
                    end else if (entry_req) begin
                        state_r        <= SERVE_ENTRY;
                        served_entry_r <= 1'b1;
                    end else if (exit_req) begin
                        state_r        <= SERVE_EXIT;
                        served_entry_r <= 1'b0;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                SERVE_ENTRY: begin
                    entry_ack_r    <= 1'b1;
                    entry_reject_r <= (free_pick_s == ZERO_LOC);
                    entry_loc_r    <= free_pick_s;
                    state_r        <= WAIT_DROP;
                end
                SERVE_EXIT: begin
                    exit_ack_r <= 1'b1;
                    exit_err_r <= ~exit_ok_s;
                    state_r    <= WAIT_DROP;
                end
                WAIT_DROP: begin
                    if (!served_req_s) begin
                        entry_ack_r    <= 1'b0;
                        entry_reject_r <= 1'b0;
                        entry_loc_r    <= ZERO_LOC;
                        exit_ack_r     <= 1'b0;
                        exit_err_r     <= 1'b0;
                        state_r        <= IDLE;
                    end else begin
                        state_r <= WAIT_DROP;
                    end
                end
                default: begin
                    entry_ack_r    <= 1'b0;
                    entry_reject_r <= 1'b0;
                    entry_loc_r    <= ZERO_LOC;
                    exit_ack_r     <= 1'b0;
                    exit_err_r     <= 1'b0;
                    state_r        <= IDLE;
                end
            endcase
        end
    end

`ifdef PARK_STATS_EN
    logic [15:0] entry_total_r;
    logic [15:0] reject_total_r;

    // Saturating counters of accepted and rejected entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry_total_r  <= 16'h0000;
            reject_total_r <= 16'h0000;
        end else if (state_r == SERVE_ENTRY) begin
            if (free_pick_s != ZERO_LOC) begin
                if (entry_total_r != 16'hFFFF) begin
                    entry_total_r <= entry_total_r + 16'h0001;
                end else begin
                    entry_total_r <= entry_total_r;
                end
            end else begin
                if (reject_total_r != 16'hFFFF) begin
                    reject_total_r <= reject_total_r + 16'h0001;
                end else begin
                    reject_total_r <= reject_total_r;
                end
            end
        end else begin
            entry_total_r  <= entry_total_r;
            reject_total_r <= reject_total_r;
        end
    end

    assign entry_total  = entry_total_r;
    assign reject_total = reject_total_r;
`else
    assign entry_total  = 16'h0000;
    assign reject_total = 16'h0000;
`endif

    assign entry_ack    = entry_ack_r;
    assign entry_reject = entry_reject_r;
    assign entry_loc    = entry_loc_r;
    assign exit_ack     = exit_ack_r;
    assign exit_err     = exit_err_r;
    assign occupancy    = occupancy_r;
    assign free_count   = free_count_r;
    assign full         = full_r;
    assign empty        = empty_r;

endmodule

// File: tb/tb_parking_slot_controller.sv
// -----------------------------------------------------------------------------
// tb_parking_slot_controller
//   Directed self-checking bench for parking_slot_controller (N_SPOTS=8).
//   Expected values are hand-computed. Outputs are sampled 1 ns after the
//   rising edge.
// -----------------------------------------------------------------------------
module tb_parking_slot_controller;

    logic        clk;
    logic        rst_n;
    logic        entry_req;
    logic        entry_ack;
    logic        entry_reject;
    logic [7:0]  entry_loc;
    logic        exit_req;
    logic [7:0]  exit_loc;
    logic        exit_ack;
    logic        exit_err;
    logic [7:0]  occupancy;
    logic [3:0]  free_count;
    logic        full;
    logic        empty;
    logic [15:0] entry_total;
    logic [15:0] reject_total;

    int total;
    int bad;

    parking_slot_controller #(.N_SPOTS(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .entry_req    (entry_req),
        .entry_ack    (entry_ack),
        .entry_reject (entry_reject),
        .entry_loc    (entry_loc),
        .exit_req     (exit_req),
        .exit_loc     (exit_loc),
        .exit_ack     (exit_ack),
        .exit_err     (exit_err),
        .occupancy    (occupancy),
        .free_count   (free_count),
        .full         (full),
        .empty        (empty),
        .entry_total  (entry_total),
        .reject_total (reject_total)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        entry_req = 1'b0;
        exit_req  = 1'b0;
        exit_loc  = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic entry_txn(output logic [7:0] loc, output logic rej);
        int n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        entry_req = 1'b1;
        while (!seen && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (entry_ack) seen = 1'b1;
        end
        check_val("entry_ack_wait", {31'd0, seen}, 32'd1);
        loc = entry_loc;
        rej = entry_reject;
        @(negedge clk);
        entry_req = 1'b0;
        @(posedge clk);
        #1;
        check_val("entry_ack_drop", {31'd0, entry_ack}, 32'd0);
    endtask

    task automatic exit_txn(input logic [7:0] loc, output logic err);
        int n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        @(negedge clk);
        exit_req = 1'b1;
        exit_loc = loc;
        while (!seen && n < 10) begin
            @(posedge clk);
            #1;
            n++;
            if (exit_ack) seen = 1'b1;
        end
        check_val("exit_ack_wait", {31'd0, seen}, 32'd1);
        err = exit_err;
        @(negedge clk);
        exit_req = 1'b0;
        @(posedge clk);
        #1;
        check_val("exit_ack_drop", {31'd0, exit_ack}, 32'd0);
    endtask

    initial begin
        logic [7:0] loc;
        logic       rej;
        logic       err;
        logic [7:0] fill_tbl [4];
        logic [7:0] drop_tbl [4];
        total = 0;
        bad   = 0;
        fill_tbl = '{8'h10, 8'h20, 8'h40, 8'h80};
        drop_tbl = '{8'h04, 8'h08, 8'h10, 8'h20};

        // ---- reset state ----
        apply_reset();
        #1;
        check_val("rst_occ",   {24'd0, occupancy}, 32'h00);
        check_val("rst_free",  {28'd0, free_count}, 32'd8);
        check_val("rst_empty", {31'd0, empty}, 32'd1);
        check_val("rst_full",  {31'd0, full}, 32'd0);
        check_val("rst_acks",  {30'd0, entry_ack, exit_ack}, 32'd0);
        check_val("rst_etot",  {16'd0, entry_total}, 32'd0);

        // ---- test 1: first entry, exact latency ----
        @(negedge clk);
        entry_req = 1'b1;
        @(posedge clk); #1;
        check_val("t1_ack_e1", {31'd0, entry_ack}, 32'd0);
        @(posedge clk); #1;
        check_val("t1_ack_e2", {31'd0, entry_ack}, 32'd1);
        check_val("t1_loc",    {24'd0, entry_loc}, 32'h01);
        check_val("t1_occ",    {24'd0, occupancy}, 32'h01);
        check_val("t1_free",   {28'd0, free_count}, 32'd7);
        check_val("t1_empty",  {31'd0, empty}, 32'd0);
        @(posedge clk); #1;
        check_val("t1_ack_hold", {31'd0, entry_ack}, 32'd1);
        @(negedge clk);
        entry_req = 1'b0;
        @(posedge clk); #1;
        check_val("t1_ack_drop", {31'd0, entry_ack}, 32'd0);
        check_val("t1_loc_drop", {24'd0, entry_loc}, 32'h00);

        // ---- test 2: build 8'h0B, then lowest free is bit 2 ----
        entry_txn(loc, rej);
        check_val("t2_fill1", {24'd0, loc}, 32'h02);
        entry_txn(loc, rej);
        check_val("t2_fill2", {24'd0, loc}, 32'h04);
        entry_txn(loc, rej);
        check_val("t2_fill3", {24'd0, loc}, 32'h08);
        exit_txn(8'h04, err);
        check_val("t2_rel_err", {31'd0, err}, 32'd0);
        check_val("t2_occ_0b",  {24'd0, occupancy}, 32'h0B);
        entry_txn(loc, rej);
        check_val("t2_loc", {24'd0, loc}, 32'h04);
        check_val("t2_rej", {31'd0, rej}, 32'd0);
        check_val("t2_occ", {24'd0, occupancy}, 32'h0F);

        // ---- test 3: fill, then reject on full lot ----
        for (int i = 0; i < 4; i++) begin
            entry_txn(loc, rej);
            check_val("t3_fill", {24'd0, loc}, {24'd0, fill_tbl[i]});
        end
        check_val("t3_occ_ff", {24'd0, occupancy}, 32'hFF);
        check_val("t3_full",   {31'd0, full}, 32'd1);
        check_val("t3_free0",  {28'd0, free_count}, 32'd0);
        entry_txn(loc, rej);
        check_val("t3_rej",     {31'd0, rej}, 32'd1);
        check_val("t3_rej_loc", {24'd0, loc}, 32'h00);
        check_val("t3_occ_kept", {24'd0, occupancy}, 32'hFF);
`ifdef PARK_STATS_EN
        check_val("t3_rtot", {16'd0, reject_total}, 32'd1);
        check_val("t3_etot", {16'd0, entry_total}, 32'd9);
`else
        check_val("t3_rtot", {16'd0, reject_total}, 32'd0);
        check_val("t3_etot", {16'd0, entry_total}, 32'd0);
`endif

        // ---- test 4: exits from 8'hC3 ----
        for (int i = 0; i < 4; i++) begin
            exit_txn(drop_tbl[i], err);
            check_val("t4_drop_err", {31'd0, err}, 32'd0);
        end
        check_val("t4_occ_c3", {24'd0, occupancy}, 32'hC3);
        exit_txn(8'h02, err);
        check_val("t4_err_ok", {31'd0, err}, 32'd0);
        check_val("t4_occ_c1", {24'd0, occupancy}, 32'hC1);
        check_val("t4_free",   {28'd0, free_count}, 32'd5);
        exit_txn(8'h04, err);
        check_val("t4_err_free", {31'd0, err}, 32'd1);
        check_val("t4_occ_same", {24'd0, occupancy}, 32'hC1);
        exit_txn(8'h03, err);
        check_val("t4_err_multi", {31'd0, err}, 32'd1);
        check_val("t4_occ_same2", {24'd0, occupancy}, 32'hC1);

        // ---- test 5: simultaneous requests, alternating priority ----
        apply_reset();
        @(negedge clk);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_loc  = 8'h01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("t5_exit_first",  {31'd0, exit_ack}, 32'd1);
        check_val("t5_entry_wait",  {31'd0, entry_ack}, 32'd0);
        check_val("t5_exit_err",    {31'd0, exit_err}, 32'd1);
        @(negedge clk);
        exit_req = 1'b0;
        @(posedge clk); #1;
        check_val("t5_exit_drop", {31'd0, exit_ack}, 32'd0);
        @(posedge clk); #1;
        check_val("t5_entry_e1", {31'd0, entry_ack}, 32'd0);
        @(posedge clk); #1;
        check_val("t5_entry_ack", {31'd0, entry_ack}, 32'd1);
        check_val("t5_entry_loc", {24'd0, entry_loc}, 32'h01);
        @(negedge clk);
        entry_req = 1'b0;
        @(posedge clk); #1;
        check_val("t5_entry_drop", {31'd0, entry_ack}, 32'd0);
        @(negedge clk);
        entry_req = 1'b1;
        exit_req  = 1'b1;
        exit_loc  = 8'h01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("t5b_entry_first", {31'd0, entry_ack}, 32'd1);
        check_val("t5b_exit_wait",   {31'd0, exit_ack}, 32'd0);
        check_val("t5b_occ",         {24'd0, occupancy}, 32'h03);
        @(negedge clk);
        entry_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("t5b_exit_ack", {31'd0, exit_ack}, 32'd1);
        check_val("t5b_exit_err", {31'd0, exit_err}, 32'd0);
        check_val("t5b_occ2",     {24'd0, occupancy}, 32'h02);
        @(negedge clk);
        exit_req = 1'b0;
        @(posedge clk); #1;
        check_val("t5b_exit_drop", {31'd0, exit_ack}, 32'd0);

        // ---- test 6: async reset during WAIT_DROP ----
        apply_reset();
        @(negedge clk);
        entry_req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_val("t6_pre_ack", {31'd0, entry_ack}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_val("t6_ack",   {31'd0, entry_ack}, 32'd0);
        check_val("t6_occ",   {24'd0, occupancy}, 32'h00);
        check_val("t6_empty", {31'd0, empty}, 32'd1);
        check_val("t6_free",  {28'd0, free_count}, 32'd8);
        entry_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_val("t6_idle_ack", {31'd0, entry_ack}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
